instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of the decode mux. Holds the PC and issues reads to the

---
 rtl/instr_fetch_unit_pkg.sv | 12 +
 rtl/fetch_buffer.sv | 48 ++++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared ISA field definitions for the fetch stage
package instr_fetch_unit_pkg;

    localparam int OPC_W = 6;
    localparam logic [OPC_W-1:0] OPC_HALT = 6'b111111;

    // True when the opcode field marks the instruction as HALT
    function automatic logic is_halt(input logic [OPC_W-1:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous FIFO holding fetched {pc, instr} entries
module fetch_buffer #(
    parameter int W     = 40,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push is legal when full and popping
    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards everything at once
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC sequencing, imem issue and decode handoff
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              INSTR_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    output logic               halted
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int ENT_W = PC_W + INSTR_W;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    inflight_pc;
    logic               inflight;
    logic               issue;
    logic               deq;
    logic               push;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit;
    logic [ENT_W-1:0]   head;
    logic [INSTR_W-1:0] last_instr;
    logic [PC_W-1:0]    last_pc;

    assign dec_valid = (count != '0);
    assign deq       = dec_valid && dec_ready;

    // Slots already promised: buffered words plus the one in flight, less what leaves now
    assign credit = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(deq);
    assign issue  = !rst && !halted && !redirect_valid && (credit < (CNT_W + 1)'(BUF_DEPTH));

    // A returning word is dropped if a redirect flushes this cycle or a HALT ahead of it stopped fetch
    assign push = inflight && !redirect_valid && !halted;

    assign imem_en   = issue;
    assign imem_addr = pc;

    // While empty the decode outputs keep showing the last word handed over
    assign dec_instr = dec_valid ? head[INSTR_W-1:0]     : last_instr;
    assign dec_pc    = dec_valid ? head[ENT_W-1:INSTR_W] : last_pc;

    fetch_buffer #(
        .W     (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (deq),
        .head_data (head),
        .count     (count)
    );

    // PC, in-flight tracking and halt state; redirect overrides normal sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            halted      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (redirect_valid) pc <= redirect_pc;
            else if (issue)     pc <= pc + PC_W'(1);
            if (redirect_valid) halted <= 1'b0;
            else if (push && is_halt(imem_rdata[INSTR_W-1 -: OPC_W])) halted <= 1'b1;
        end
    end

    // Remember the most recently delivered word for the empty-buffer outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            last_instr <= '0;
            last_pc    <= '0;
        end else if (deq) begin
            last_instr <= head[INSTR_W-1:0];
            last_pc    <= head[ENT_W-1:INSTR_W];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instr;
    logic [7:0]  dec_pc;
    logic        halted;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after the strobe
    logic [31:0] mem [256];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the delivered stream must be consecutive words from the
    // last reset/redirect target, each equal to memory, ending with a HALT word.
    logic [7:0]  exp_pc = 8'h00;
    bit          halt_seen = 1'b0;
    bit          prev_flush = 1'b1;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_pc;
    logic [31:0] prev_instr;
    int          stall = 0;
    int          transfers = 0;

    task automatic monitor();
        logic [31:0] w;
        if (prev_flush) begin
            chk_eq("valid_after_flush", dec_valid, 0);
            chk_eq("halted_after_flush", halted, 0);
        end
        if (prev_hold) begin
            chk_eq("hold_valid", dec_valid, 1);
            chk_eq("hold_pc", dec_pc, prev_pc);
            chk_eq("hold_instr", dec_instr, prev_instr);
        end
        if (rst || redirect_valid) chk_eq("en_blocked", imem_en, 0);
        if (halted) chk_eq("en_while_halted", imem_en, 0);
        if (halt_seen) begin
            chk_eq("en_after_halt", imem_en, 0);
            chk_eq("valid_after_halt", dec_valid, 0);
        end
        if (dec_valid && dec_ready && !rst) begin
            w = mem[exp_pc];
            chk_eq("deliver_after_halt", halt_seen, 0);
            chk_eq("stream_pc", dec_pc, exp_pc);
            chk_eq("stream_instr", dec_instr, w);
            if (w[31:26] == 6'h3f) begin
                chk_eq("halted_on_halt", halted, 1);
                halt_seen = 1'b1;
            end
            exp_pc = exp_pc + 8'd1;
            transfers++;
            stall = 0;
        end else if (dec_ready && !halt_seen && !rst && !redirect_valid) begin
            stall++;
        end
        chk_eq("no_bubble_stall", stall > 3, 0);
        if (stall > 3) stall = 0;
        if (rst) begin
            exp_pc = 8'h00;
            halt_seen = 1'b0;
            stall = 0;
        end else if (redirect_valid) begin
            exp_pc = redirect_pc;
            halt_seen = 1'b0;
            stall = 0;
        end
        prev_flush = rst || redirect_valid;
        prev_hold  = dec_valid && !dec_ready && !rst && !redirect_valid;
        prev_pc    = dec_pc;
        prev_instr = dec_instr;
    endtask

    // Called at posedge+2 with inputs settled; runs the model and advances a cycle
    task automatic tick();
        monitor();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [7:0]  rpc;
        logic        ready;
        logic        exp_en;
        logic        exp_valid;
        logic [7:0]  exp_pc;
        logic [31:0] exp_instr;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int          en_cnt;
        int          v_cnt;
        int          got;
        int          lat;
        bit          found;
        logic [7:0]  seq [4];
        logic [7:0]  wrap_exp [4];
        logic [31:0] rw;

        for (int i = 0; i < 256; i++) mem[i] = i;

        // Cycle-by-cycle expectations from reset with mem[i] = i
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 32'h00, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 32'h01, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 32'h02, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 32'h03, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 32'h03, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 32'h03, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 32'h04, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 8'h05, 32'h05, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h05, 32'h05, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h05, 32'h05, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40, 32'h40, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h41, 32'h41, 1'b0};

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            rst            = vecs[i].rst;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            dec_ready      = vecs[i].ready;
            #1;
            chk_eq($sformatf("vec%0d_en", i), imem_en, vecs[i].exp_en);
            chk_eq($sformatf("vec%0d_valid", i), dec_valid, vecs[i].exp_valid);
            chk_eq($sformatf("vec%0d_pc", i), dec_pc, vecs[i].exp_pc);
            chk_eq($sformatf("vec%0d_instr", i), dec_instr, vecs[i].exp_instr);
            chk_eq($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halted);
            tick();
        end

        // Back-pressure: five stalled cycles after a redirect allow only two fetches
        redirect_valid = 1'b1; redirect_pc = 8'h80; dec_ready = 1'b1;
        #1; tick();
        redirect_valid = 1'b0; dec_ready = 1'b0;
        en_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            en_cnt += int'(imem_en);
            tick();
        end
        chk_eq("stall_en_pulses", en_cnt, 2);
        #1;
        chk_eq("stall_head_pc", dec_pc, 8'h80);
        dec_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1; tick();
            if (exp_pc == 8'h84) break;
        end
        chk_eq("stall_release_drained", exp_pc, 8'h84);

        // Redirect at peak occupancy (one buffered, one in flight, decode stalled)
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40;
        #1; tick();
        redirect_valid = 1'b0; dec_ready = 1'b1;
        found = 1'b0; lat = 0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (!found && dec_valid) begin
                found = 1'b1;
                lat = k;
                chk_eq("redirect_first_pc", dec_pc, 8'h40);
            end
            tick();
            if (found) break;
        end
        chk_eq("redirect_found", found, 1);
        chk_eq("redirect_latency", lat, 3);

        // HALT at address 5 ends the stream
        rst = 1'b1;
        mem[5] = 32'hFC000000;
        #1; tick();
        rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (dec_valid && dec_ready && dec_pc == 8'h05) begin
                found = 1'b1;
                chk_eq("halt_word", dec_instr, 32'hFC000000);
                chk_eq("halt_flag", halted, 1);
            end
            tick();
            if (found) break;
        end
        chk_eq("halt_found", found, 1);
        en_cnt = 0; v_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            en_cnt += int'(imem_en);
            v_cnt  += int'(dec_valid);
            tick();
        end
        chk_eq("halt_no_issue", en_cnt, 0);
        chk_eq("halt_no_valid", v_cnt, 0);
        chk_eq("halt_sticky", halted, 1);

        // PC wrap: redirect to FE also leaves the halted state
        mem[5] = 32'h5;
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        #1; tick();
        redirect_valid = 1'b0;
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (dec_valid && dec_ready && got < 4) begin
                seq[got] = dec_pc;
                got++;
            end
            tick();
            if (got == 4) break;
        end
        chk_eq("wrap_count", got, 4);
        for (int i = 0; i < 4; i++) if (i < got) chk_eq($sformatf("wrap_pc%0d", i), seq[i], wrap_exp[i]);

        // One-cycle reset in mid-stream restarts at address 0
        rst = 1'b1;
        #1; tick();
        rst = 1'b0;
        found = 1'b0; lat = 0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (!found && dec_valid) begin
                found = 1'b1;
                lat = k;
                chk_eq("rst_first_pc", dec_pc, 8'h00);
            end
            tick();
            if (found) break;
        end
        chk_eq("rst_found", found, 1);
        chk_eq("rst_latency", lat, 3);

        // Randomised traffic against the stream model
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rw = $urandom;
            if ($urandom_range(63) == 0) rw[31:26] = 6'h3f;
            else if (rw[31:26] == 6'h3f) rw[31:26] = 6'h00;
            mem[i] = rw;
        end
        #1; tick();
        rst = 1'b0;
        transfers = 0;
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(255));
            dec_ready      = ($urandom_range(3) != 0);
            rst            = (r == 0);
            redirect_valid = (r >= 1 && r < 8);
            redirect_pc    = 8'($urandom);
            #1; tick();
        end
        chk_eq("random_progress", transfers > 300, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
